mem_arbiter: RTL and testbench

- Upstream stage that merges the CPU's instruction-fetch port (ie/iaddr) and data port (de/daddr/drw/din) into one serialized request stream for the single-port SRAM controller.
- Holds the CPU with cpu_stall until every requested access has completed.
- Returns fetched words on iout/dout.
- Sits between the CPU memory bus and the SRAM interface, which is a multi-cycle, one-transaction-at-a-time engine.

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges CPU fetch and data ports into one serialized SRAM request stream.
// Define MEM_ARBITER_IBUF_EN to add a single-entry instruction fetch buffer.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ie,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              de,
    input  logic [ADDR_W-1:0] daddr,
    input  logic              drw,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] iout,
    output logic [DATA_W-1:0] dout,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_drw,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_rdy,
    output logic              err
);

    localparam int WD_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (MAX_WAIT > 0) ? WD_W'(MAX_WAIT - 1) : '0;

    typedef enum logic [1:0] {IDLE, DREQ, IREQ, DONE} state_t;

    state_t            r_state;
    logic              r_ipend;
    logic [ADDR_W-1:0] r_iaddr;
    logic [DATA_W-1:0] r_ioutQ;
    logic [DATA_W-1:0] r_doutQ;
    logic              r_err;
    logic [WD_W-1:0]   r_wdog;

    logic w_busy;
    logic w_wdogHit;
    logic w_timeout;
    logic w_finish;
    logic w_hitNew;
    logic w_hitHeld;

    // The watchdog fires on the last allowed cycle so mem_req is high for exactly MAX_WAIT cycles.
    assign w_busy    = (r_state == DREQ) || (r_state == IREQ);
    assign w_wdogHit = (MAX_WAIT > 0) && (r_wdog == WD_LAST);
    assign w_timeout = w_busy && !mem_rdy && w_wdogHit;
    assign w_finish  = w_busy && (mem_rdy || w_wdogHit);

    assign cpu_stall = (ie || de) && (r_state != DONE);
    assign iout      = ie ? r_ioutQ : {DATA_W{1'bz}};
    assign dout      = de ? r_doutQ : {DATA_W{1'bz}};
    assign err       = r_err;

`ifdef MEM_ARBITER_IBUF_EN
    logic              r_ibValid;
    logic [ADDR_W-1:0] r_ibTag;
    logic              w_wrInval;

    // During DREQ mem_addr/mem_drw still hold the captured data access.
    assign w_wrInval = (r_state == DREQ) && w_finish && mem_drw &&
                       (mem_addr[ADDR_W-1:2] == r_ibTag[ADDR_W-1:2]);
    assign w_hitNew  = r_ibValid && (iaddr == r_ibTag);
    assign w_hitHeld = r_ibValid && !w_wrInval && (r_iaddr == r_ibTag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ibValid <= 1'b0;
            r_ibTag   <= '0;
        end else if ((r_state == IREQ) && w_finish) begin
            r_ibTag   <= r_iaddr;
            r_ibValid <= mem_rdy;
        end else if (w_wrInval) begin
            r_ibValid <= 1'b0;
        end
    end
`else
    assign w_hitNew  = 1'b0;
    assign w_hitHeld = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_ipend  <= 1'b0;
            r_iaddr  <= '0;
            r_ioutQ  <= '0;
            r_doutQ  <= '0;
            r_err    <= 1'b0;
            r_wdog   <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            mem_drw  <= 1'b0;
            mem_din  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ie || de) begin
                        r_ipend <= ie;
                        r_iaddr <= iaddr;
                        r_wdog  <= '0;
                        if (de) begin
                            r_state  <= DREQ;
                            mem_req  <= 1'b1;
                            mem_addr <= daddr;
                            mem_drw  <= drw;
                            mem_din  <= din;
                        end else if (w_hitNew) begin
                            r_state <= DONE;
                        end else begin
                            r_state  <= IREQ;
                            mem_req  <= 1'b1;
                            mem_addr <= iaddr;
                            mem_drw  <= 1'b0;
                        end
                    end
                end
                DREQ: begin
                    if (w_finish) begin
                        r_doutQ <= w_timeout ? '1 : (mem_drw ? '0 : mem_dout);
                        r_wdog  <= '0;
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end
                        // A pending fetch follows immediately so the SRAM sees no idle gap.
                        if (r_ipend && !w_hitHeld) begin
                            r_state  <= IREQ;
                            mem_addr <= r_iaddr;
                            mem_drw  <= 1'b0;
                        end else begin
                            r_state <= DONE;
                            mem_req <= 1'b0;
                        end
                    end else if (r_wdog != '1) begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end
                IREQ: begin
                    if (w_finish) begin
                        r_ioutQ <= w_timeout ? '1 : mem_dout;
                        r_wdog  <= '0;
                        r_state <= DONE;
                        mem_req <= 1'b0;
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end
                    end else if (r_wdog != '1) begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a queue-based
// transaction model; define MEM_ARBITER_IBUF_EN to also exercise the fetch buffer.
module tb_mem_arbiter;

    localparam int MAXW = 8;
    localparam logic [31:0] KEY = 32'h3C01DFAD;

    logic        clk;
    logic        rst;
    logic        ie;
    logic [31:0] iaddr;
    logic        de;
    logic [31:0] daddr;
    logic        drw;
    logic [31:0] din;
    wire  [31:0] iout;
    wire  [31:0] dout;
    logic        cpu_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_drw;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_rdy;
    logic        err;

    int total = 0;
    int bad   = 0;
    int latFixed = -1;
    bit spurOn = 0;

    typedef struct {
        bit          isData;
        logic [31:0] addr;
        bit          wr;
        logic [31:0] data;
    } txn_t;

    // Model state: outstanding SRAM transactions for the current request, in service order.
    txn_t        mq[$];
    bit          mDone;
    int          mWait;
    logic [31:0] mIout;
    logic [31:0] mDout;
    bit          mErr;
`ifdef MEM_ARBITER_IBUF_EN
    bit          mValid;
    logic [31:0] mTag;
`endif

    mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MAX_WAIT(MAXW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ie       (ie),
        .iaddr    (iaddr),
        .de       (de),
        .daddr    (daddr),
        .drw      (drw),
        .din      (din),
        .iout     (iout),
        .dout     (dout),
        .cpu_stall(cpu_stall),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_drw  (mem_drw),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_rdy  (mem_rdy),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a request becomes a list of SRAM accesses, each retired by
    // mem_rdy or by the watchdog limit; the request completes one cycle after the last one.
    initial begin : model
        txn_t t;
        bit   fin;
        bit   tmo;
        bit   hit;
        forever begin
            @(posedge clk);
            if (!rst) begin
                mq.delete();
                mDone = 0;
                mWait = 0;
                mIout = '0;
                mDout = '0;
                mErr  = 0;
`ifdef MEM_ARBITER_IBUF_EN
                mValid = 0;
                mTag   = '0;
`endif
            end else if (mDone) begin
                mDone = 0;
            end else if (mq.size() > 0) begin
                fin = mem_rdy || (mWait == MAXW - 1);
                tmo = fin && !mem_rdy;
                if (fin) begin
                    t = mq.pop_front();
                    mWait = 0;
                    if (tmo) mErr = 1;
                    if (t.isData) begin
                        mDout = tmo ? 32'hFFFFFFFF : (t.wr ? 32'h0 : mem_dout);
`ifdef MEM_ARBITER_IBUF_EN
                        if (t.wr && (t.addr[31:2] == mTag[31:2])) mValid = 0;
                        if (mq.size() > 0 && mValid && mq[0].addr == mTag) void'(mq.pop_front());
`endif
                    end else begin
                        mIout = tmo ? 32'hFFFFFFFF : mem_dout;
`ifdef MEM_ARBITER_IBUF_EN
                        mTag   = t.addr;
                        mValid = !tmo;
`endif
                    end
                    if (mq.size() == 0) mDone = 1;
                end else begin
                    mWait++;
                end
            end else if (ie || de) begin
                mWait = 0;
                hit = 0;
`ifdef MEM_ARBITER_IBUF_EN
                hit = mValid && (iaddr == mTag);
`endif
                if (de) begin
                    mq.push_back('{1'b1, daddr, drw, din});
                    if (ie) mq.push_back('{1'b0, iaddr, 1'b0, 32'h0});
                end else if (hit) begin
                    mDone = 1;
                end else begin
                    mq.push_back('{1'b0, iaddr, 1'b0, 32'h0});
                end
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (!rst) begin
                checkOutput("rstMemReq", 32'(mem_req), 32'h0);
                checkOutput("rstMemAddr", mem_addr, 32'h0);
                checkOutput("rstMemDrw", 32'(mem_drw), 32'h0);
                checkOutput("rstMemDin", mem_din, 32'h0);
                checkOutput("rstErr", 32'(err), 32'h0);
                checkOutput("rstStall", 32'(cpu_stall), 32'(ie || de));
                if (ie) checkOutput("rstIout", iout, 32'h0);
                if (de) checkOutput("rstDout", dout, 32'h0);
            end else begin
                checkOutput("stall", 32'(cpu_stall), 32'((ie || de) && !mDone));
                checkOutput("memReq", 32'(mem_req), 32'(mq.size() > 0));
                checkOutput("err", 32'(err), 32'(mErr));
                if (mq.size() > 0) begin
                    checkOutput("memAddr", mem_addr, mq[0].addr);
                    checkOutput("memDrw", 32'(mem_drw), 32'(mq[0].isData && mq[0].wr));
                    if (mq[0].isData && mq[0].wr) checkOutput("memDin", mem_din, mq[0].data);
                end
                if (ie) checkOutput("iout", iout, mIout);
                if (de) checkOutput("dout", dout, mDout);
            end
        end
    end

    // SRAM controller stand-in: answers each transaction after cLat cycles with addr^KEY,
    // abandons it at the watchdog limit, and optionally pulses mem_rdy while idle.
    initial begin : ctrl
        bit cActive;
        bit cEnd;
        int cCnt;
        int cLat;
        mem_rdy  = 1'b0;
        mem_dout = '0;
        cActive  = 0;
        cEnd     = 0;
        cCnt     = 0;
        cLat     = 0;
        forever begin
            @(posedge clk);
            #2;
            mem_rdy  = 1'b0;
            mem_dout = $urandom;
            if (!rst) begin
                cActive = 0;
                cEnd    = 0;
            end else begin
                if (cEnd) begin
                    cActive = 0;
                    cEnd    = 0;
                end
                if (!cActive && mem_req) begin
                    cActive = 1;
                    cCnt    = 0;
                    if (latFixed >= 0) cLat = latFixed;
                    else if ($urandom_range(0, 7) == 0) cLat = 12;
                    else cLat = int'($urandom_range(0, 4));
                end
                if (cActive) begin
                    if (cCnt == cLat) begin
                        mem_rdy  = 1'b1;
                        mem_dout = mem_addr ^ KEY;
                        cEnd     = 1;
                    end else if (cCnt == MAXW - 1) begin
                        cEnd = 1;
                    end else begin
                        cCnt++;
                    end
                end else if (spurOn && $urandom_range(0, 7) == 0) begin
                    mem_rdy = 1'b1;
                end
            end
        end
    end

    // Issue one CPU request, hold it until the stall drops, and report what was seen.
    task automatic applyStimulus(input bit tIe, input logic [31:0] tIa, input bit tDe,
                                 input logic [31:0] tDa, input bit tDrw, input logic [31:0] tDin,
                                 input int lat, output int stallN, output int reqN,
                                 output logic [31:0] firstAddr, output logic [31:0] iv,
                                 output logic [31:0] dv);
        bit seenDone;
        @(posedge clk);
        #1;
        latFixed = lat;
        ie = tIe; iaddr = tIa; de = tDe; daddr = tDa; drw = tDrw; din = tDin;
        stallN = 0; reqN = 0; firstAddr = '0; iv = '0; dv = '0; seenDone = 0;
        for (int c = 0; c < 200 && !seenDone; c++) begin
            @(negedge clk);
            if (mem_req) begin
                if (reqN == 0) firstAddr = mem_addr;
                reqN++;
            end
            if (cpu_stall) stallN++;
            else begin
                iv = iout;
                dv = dout;
                seenDone = 1;
            end
        end
        if (!seenDone) begin
            total++;
            bad++;
            $display("[TB] FAIL reqTimeout: got stall still high expected release within 200 cycles");
        end
        @(posedge clk);
        #1;
        ie = 1'b0;
        de = 1'b0;
    endtask

    initial begin : main
        int          stallN;
        int          reqN;
        logic [31:0] fa;
        logic [31:0] iv;
        logic [31:0] dv;
        int          sel;
        logic [31:0] iaddrs[4];
        logic [31:0] daddrs[5];

        iaddrs = '{32'h100, 32'h104, 32'h200, 32'h300};
        daddrs = '{32'h100, 32'h102, 32'h104, 32'h8000, 32'h40};
        ie = 0; de = 0; drw = 0; iaddr = '0; daddr = '0; din = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("initReq", 32'(mem_req), 32'h0);
        checkOutput("initErr", 32'(err), 32'h0);
        checkOutput("initStall", 32'(cpu_stall), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        $display("[TB] instruction-only fetch");
        applyStimulus(1, 32'h100, 0, 32'h0, 0, 32'h0, 5, stallN, reqN, fa, iv, dv);
        checkOutput("fetchIout", iv, 32'h3C01DEAD);
        checkOutput("fetchStall", 32'(stallN), 32'd7);
        checkOutput("fetchReqCycles", 32'(reqN), 32'd6);

        $display("[TB] simultaneous data read and fetch");
        applyStimulus(1, 32'h200, 1, 32'h8000, 0, 32'h0, 2, stallN, reqN, fa, iv, dv);
        checkOutput("dualFirstAddr", fa, 32'h8000);
        checkOutput("dualDout", dv, 32'h3C015FAD);
        checkOutput("dualIout", iv, 32'h3C01DDAD);
        checkOutput("dualStall", 32'(stallN), 32'd7);

        $display("[TB] data write");
        applyStimulus(0, 32'h0, 1, 32'h40, 1, 32'hA5A5A5A5, 3, stallN, reqN, fa, iv, dv);
        checkOutput("writeDout", dv, 32'h0);
        checkOutput("writeStall", 32'(stallN), 32'd5);

        $display("[TB] watchdog");
        applyStimulus(1, 32'h300, 0, 32'h0, 0, 32'h0, 100, stallN, reqN, fa, iv, dv);
        checkOutput("wdReqCycles", 32'(reqN), 32'd8);
        checkOutput("wdIout", iv, 32'hFFFFFFFF);
        checkOutput("wdStall", 32'(stallN), 32'd9);
        repeat (3) @(negedge clk);
        checkOutput("wdErrSticky", 32'(err), 32'h1);

        $display("[TB] reset during data request");
        @(posedge clk);
        #1;
        latFixed = 100;
        de = 1; daddr = 32'h500; drw = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midRstReq", 32'(mem_req), 32'h0);
        checkOutput("midRstStall", 32'(cpu_stall), 32'h1);
        checkOutput("midRstErr", 32'(err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        de = 1'b0;
        @(negedge clk);
        checkOutput("postRstStall", 32'(cpu_stall), 32'h0);
        checkOutput("postRstReq", 32'(mem_req), 32'h0);

`ifdef MEM_ARBITER_IBUF_EN
        $display("[TB] fetch buffer");
        applyStimulus(1, 32'h100, 0, 32'h0, 0, 32'h0, 2, stallN, reqN, fa, iv, dv);
        checkOutput("ibMissReq", 32'(reqN), 32'd3);
        applyStimulus(1, 32'h100, 0, 32'h0, 0, 32'h0, 2, stallN, reqN, fa, iv, dv);
        checkOutput("ibHitReq", 32'(reqN), 32'd0);
        checkOutput("ibHitStall", 32'(stallN), 32'd1);
        checkOutput("ibHitIout", iv, 32'h3C01DEAD);
        applyStimulus(1, 32'h100, 1, 32'h8000, 0, 32'h0, 1, stallN, reqN, fa, iv, dv);
        checkOutput("ibDualHitReq", 32'(reqN), 32'd2);
        checkOutput("ibDualHitDout", dv, 32'h3C015FAD);
        applyStimulus(0, 32'h0, 1, 32'h100, 1, 32'h12345678, 1, stallN, reqN, fa, iv, dv);
        applyStimulus(1, 32'h100, 0, 32'h0, 0, 32'h0, 2, stallN, reqN, fa, iv, dv);
        checkOutput("ibInvalReq", 32'(reqN), 32'd3);
        checkOutput("ibInvalIout", iv, 32'h3C01DEAD);
`endif

        $display("[TB] randomized traffic");
        latFixed = -1;
        spurOn   = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst = 1'b0;
            if (mq.size() == 0 && !mDone) begin
                sel   = int'($urandom_range(0, 3));
                ie    = (sel == 1) || (sel == 3);
                de    = (sel >= 2);
                iaddr = iaddrs[$urandom_range(0, 3)];
                daddr = daddrs[$urandom_range(0, 4)];
                drw   = 1'($urandom_range(0, 1));
                din   = $urandom;
            end else if (mq.size() > 0) begin
                iaddr = $urandom;
                daddr = $urandom;
                drw   = 1'($urandom_range(0, 1));
                din   = $urandom;
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        ie  = 1'b0;
        de  = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
